// File: rtl/debug_axi_writer.sv
// Buffers 16 stream samples, then writes them to DDR as one AXI4 INCR burst.
// Ports: stream in (in_*), run control (write_*), AXI4 write channels (AXI_writer_axi_*).
module debug_axi_writer #(
  parameter int unsigned TOTAL_PACKAGE    = 416,
  parameter int unsigned DATA_DEPTH       = 16,
  parameter int unsigned DATA_DEPTH_INDEX = 4,
  parameter int unsigned DATA_BYTE_SHIFT  = 5,
  parameter int unsigned DATA_BYTE_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         write_start,
  input  logic [31:0]                  AXI_writer_axi_awaddr_start,
  output logic                         write_done,
  output logic                         write_err,
  input  logic [DATA_BYTE_WIDTH*8-1:0] in_data,
  input  logic                         in_vld,
  output logic                         in_rdy,
  output logic [3:0]                   AXI_writer_axi_awid,
  output logic [31:0]                  AXI_writer_axi_awaddr,
  output logic [7:0]                   AXI_writer_axi_awlen,
  output logic [2:0]                   AXI_writer_axi_awsize,
  output logic [1:0]                   AXI_writer_axi_awburst,
  output logic                         AXI_writer_axi_awvalid,
  input  logic                         AXI_writer_axi_awready,
  output logic [DATA_BYTE_WIDTH*8-1:0] AXI_writer_axi_wdata,
  output logic [DATA_BYTE_WIDTH-1:0]   AXI_writer_axi_wstrb,
  output logic                         AXI_writer_axi_wlast,
  output logic                         AXI_writer_axi_wvalid,
  input  logic                         AXI_writer_axi_wready,
  input  logic [3:0]                   AXI_writer_axi_bid,
  input  logic [1:0]                   AXI_writer_axi_bresp,
  input  logic                         AXI_writer_axi_bvalid,
  output logic                         AXI_writer_axi_bready
);

  localparam int unsigned DW    = DATA_BYTE_WIDTH * 8;
  localparam int unsigned DI    = DATA_DEPTH_INDEX;
  localparam int unsigned PKG_W = $clog2(TOTAL_PACKAGE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_AW,
    S_W,
    S_B
  } state_e;

  state_e            state_q, state_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              in_rdy_q, in_rdy_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic [31:0]       awaddr_q, awaddr_d;
  logic [31:0]       base_q, base_d;
  logic [PKG_W-1:0]  pkg_q, pkg_d;
  logic [DI-1:0]     fill_q, fill_d;
  logic [DI-1:0]     wcnt_q, wcnt_d;
  logic [DW-1:0]     data_buf_q [DATA_DEPTH];

  logic in_acc, aw_hs, w_hs, b_hs, wlast;
  logic unused_bid;

  assign in_acc = in_vld & in_rdy_q;
  assign aw_hs  = awvalid_q & AXI_writer_axi_awready;
  assign w_hs   = wvalid_q & AXI_writer_axi_wready;
  assign b_hs   = AXI_writer_axi_bvalid & bready_q;
  assign wlast  = wvalid_q & (wcnt_q == DI'(DATA_DEPTH - 1));

  assign unused_bid = ^AXI_writer_axi_bid;

  always_comb begin
    state_d   = state_q;
    done_d    = done_q;
    err_d     = err_q;
    in_rdy_d  = in_rdy_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    awaddr_d  = awaddr_q;
    base_d    = base_q;
    pkg_d     = pkg_q;
    fill_d    = fill_q;
    wcnt_d    = wcnt_q;
    unique case (state_q)
      S_IDLE: begin
        done_d = 1'b1;
        if (write_start) begin
          base_d   = AXI_writer_axi_awaddr_start;
          pkg_d    = '0;
          err_d    = 1'b0;
          done_d   = 1'b0;
          fill_d   = '0;
          in_rdy_d = 1'b1;
          state_d  = S_FILL;
        end
      end
      S_FILL: begin
        if (in_acc) begin
          fill_d = fill_q + 1'b1;
          // Buffer full: close input before a 17th sample can land.
          if (fill_q == DI'(DATA_DEPTH - 1)) begin
            in_rdy_d  = 1'b0;
            awvalid_d = 1'b1;
            awaddr_d  = base_q
                      + (32'(pkg_q) << DATA_BYTE_SHIFT);
            state_d   = S_AW;
          end
        end
      end
      S_AW: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          wcnt_d    = '0;
          state_d   = S_W;
        end
      end
      S_W: begin
        if (w_hs) begin
          wcnt_d = wcnt_q + 1'b1;
          pkg_d  = pkg_q + 1'b1;
          if (wlast) begin
            wvalid_d = 1'b0;
            bready_d = 1'b1;
            state_d  = S_B;
          end
        end
      end
      S_B: begin
        if (b_hs) begin
          bready_d = 1'b0;
          err_d    = err_q | (AXI_writer_axi_bresp != 2'b00);
          if (pkg_q >= PKG_W'(TOTAL_PACKAGE)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            fill_d   = '0;
            in_rdy_d = 1'b1;
            state_d  = S_FILL;
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        done_d    = 1'b1;
        err_d     = 1'b0;
        in_rdy_d  = 1'b0;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        awaddr_d  = '0;
        base_d    = '0;
        pkg_d     = '0;
        fill_d    = '0;
        wcnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      done_q    <= 1'b1;
      err_q     <= 1'b0;
      in_rdy_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      awaddr_q  <= '0;
      base_q    <= '0;
      pkg_q     <= '0;
      fill_q    <= '0;
      wcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      err_q     <= err_d;
      in_rdy_q  <= in_rdy_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      awaddr_q  <= awaddr_d;
      base_q    <= base_d;
      pkg_q     <= pkg_d;
      fill_q    <= fill_d;
      wcnt_q    <= wcnt_d;
    end
  end

  // Sample storage carries no reset; it is always refilled before use.
  always_ff @(posedge clk) begin
    if (state_q == S_FILL && in_acc) begin
      data_buf_q[fill_q] <= in_data;
    end
  end

  assign write_done             = done_q;
  assign write_err              = err_q;
  assign in_rdy                 = in_rdy_q;
  assign AXI_writer_axi_awid    = 4'b0000;
  assign AXI_writer_axi_awaddr  = awaddr_q;
  assign AXI_writer_axi_awlen   = 8'(DATA_DEPTH - 1);
  assign AXI_writer_axi_awsize  = 3'(DATA_BYTE_SHIFT);
  assign AXI_writer_axi_awburst = 2'b01;
  assign AXI_writer_axi_awvalid = awvalid_q;
  assign AXI_writer_axi_wdata   = data_buf_q[wcnt_q];
  assign AXI_writer_axi_wstrb   = '1;
  assign AXI_writer_axi_wlast   = wlast;
  assign AXI_writer_axi_wvalid  = wvalid_q;
  assign AXI_writer_axi_bready  = bready_q;

endmodule

// File: tb/tb_debug_axi_writer.sv
// Randomized scoreboard bench for debug_axi_writer.
// Drivers run after posedge; the monitor samples on negedge.
module tb_debug_axi_writer;

  localparam int TOTAL  = 416;
  localparam int DEPTH  = 16;
  localparam int NBURST = TOTAL / DEPTH;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         write_start = 1'b0;
  logic [31:0]  awaddr_start = '0;
  logic         write_done, write_err;
  logic [255:0] in_data = '0;
  logic         in_vld = 1'b0;
  logic         in_rdy;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready = 1'b0;
  logic [255:0] wdata;
  logic [31:0]  wstrb;
  logic         wlast, wvalid;
  logic         wready = 1'b0;
  logic [3:0]   bid = '0;
  logic [1:0]   bresp = '0;
  logic         bvalid = 1'b0;
  logic         bready;

  debug_axi_writer dut (
    .clk(clk),
    .rst(rst),
    .write_start(write_start),
    .AXI_writer_axi_awaddr_start(awaddr_start),
    .write_done(write_done),
    .write_err(write_err),
    .in_data(in_data),
    .in_vld(in_vld),
    .in_rdy(in_rdy),
    .AXI_writer_axi_awid(awid),
    .AXI_writer_axi_awaddr(awaddr),
    .AXI_writer_axi_awlen(awlen),
    .AXI_writer_axi_awsize(awsize),
    .AXI_writer_axi_awburst(awburst),
    .AXI_writer_axi_awvalid(awvalid),
    .AXI_writer_axi_awready(awready),
    .AXI_writer_axi_wdata(wdata),
    .AXI_writer_axi_wstrb(wstrb),
    .AXI_writer_axi_wlast(wlast),
    .AXI_writer_axi_wvalid(wvalid),
    .AXI_writer_axi_wready(wready),
    .AXI_writer_axi_bid(bid),
    .AXI_writer_axi_bresp(bresp),
    .AXI_writer_axi_bvalid(bvalid),
    .AXI_writer_axi_bready(bready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input bit ok, input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model state
  logic [255:0] exp_data[$];
  logic [31:0]  exp_addr[$];
  bit  exp_done = 1'b1;
  bit  exp_err  = 1'b0;
  bit  mon_en   = 1'b0;
  int  bursts_seen = 0;
  int  beats_total = 0;
  int  beat_in_burst = 0;
  int  fill_acc = 0;
  bit  aw_done = 1'b0;
  int  aw_hi_cnt = 0;
  bit  prev_awvalid = 1'b0;
  logic [31:0] prev_awaddr = '0;

  // Stimulus modes
  bit in_rand = 0, wr_rand = 0, b_rand = 0, aw_rand = 0;
  int aw_delay = 0;
  int aw_hi_drv = 0;
  int bad_burst = -1;

  always @(posedge clk) begin
    #1;
    in_data = {8{$urandom}};
    in_vld  = in_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    wready  = wr_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    bid     = 4'($urandom);
    if (!awvalid) begin
      awready   = 1'b0;
      aw_hi_drv = 0;
      if (aw_rand) aw_delay = $urandom_range(0, 3);
    end else begin
      awready = (aw_hi_drv >= aw_delay);
      aw_hi_drv++;
    end
    bvalid = bready & (b_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    bresp  = (bursts_seen == bad_burst) ? 2'b10 : 2'b00;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      // every accepted sample must reappear on W in order
      if (in_vld && in_rdy) begin
        chk(fill_acc < DEPTH, "no_17th_accept", fill_acc, DEPTH - 1);
        fill_acc++;
        exp_data.push_back(in_data);
      end
      if (write_done || awvalid || wvalid || bready)
        chk(in_rdy == 1'b0, "in_rdy_outside_fill", in_rdy, 0);
      chk(write_done == exp_done, "write_done", write_done, exp_done);
      chk(write_err == exp_err, "write_err", write_err, exp_err);
      if (awvalid) begin
        if (prev_awvalid)
          chk(awaddr == prev_awaddr, "awaddr_stable", awaddr, prev_awaddr);
        aw_hi_cnt++;
        if (awready) begin
          if (exp_addr.size() == 0) begin
            chk(1'b0, "aw_unexpected", awaddr, 0);
          end else begin
            logic [31:0] ea;
            ea = exp_addr.pop_front();
            chk(awaddr == ea, "awaddr", awaddr, ea);
          end
          chk({awid, awlen, awsize, awburst} == {4'h0, 8'd15, 3'b101, 2'b01},
              "aw_consts", {awid, awlen, awsize, awburst},
              {4'h0, 8'd15, 3'b101, 2'b01});
          chk(aw_hi_cnt == aw_delay + 1, "aw_hold_cycles",
              aw_hi_cnt, aw_delay + 1);
          aw_done = 1'b1;
          aw_hi_cnt = 0;
          beat_in_burst = 0;
        end
      end
      prev_awvalid = awvalid && !awready;
      prev_awaddr  = awaddr;
      if (wvalid) chk(aw_done, "w_after_aw", wvalid, 0);
      else chk(wlast == 1'b0, "wlast_idle", wlast, 0);
      if (wvalid && wready) begin
        if (exp_data.size() == 0) begin
          chk(1'b0, "w_unexpected", wdata, 0);
        end else begin
          logic [255:0] ed;
          ed = exp_data.pop_front();
          chk(wdata == ed, "wdata", wdata, ed);
        end
        chk(wlast == (beat_in_burst == DEPTH - 1), "wlast",
            wlast, beat_in_burst == DEPTH - 1);
        chk(wstrb == 32'hFFFF_FFFF, "wstrb", wstrb, 32'hFFFF_FFFF);
        beat_in_burst++;
        beats_total++;
      end
      if (bvalid && bready) begin
        chk(beat_in_burst == DEPTH, "beats_per_burst", beat_in_burst, DEPTH);
        if (bursts_seen == bad_burst) exp_err = 1'b1;
        bursts_seen++;
        fill_acc = 0;
        aw_done  = 1'b0;
        if (bursts_seen == NBURST) exp_done = 1'b1;
      end
      if (write_start && exp_done) begin
        exp_done = 1'b0;
        exp_err  = 1'b0;
      end
    end
  end

  task automatic clear_model();
    exp_data.delete();
    exp_addr.delete();
    exp_done = 1'b1;
    exp_err = 1'b0;
    bursts_seen = 0;
    beats_total = 0;
    beat_in_burst = 0;
    fill_acc = 0;
    aw_done = 1'b0;
    aw_hi_cnt = 0;
    prev_awvalid = 1'b0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk(write_done == 1'b1, "rst_done", write_done, 1);
    chk({write_err, in_rdy, awvalid, wvalid, bready, wlast} == 6'b0,
        "rst_ctrl", {write_err, in_rdy, awvalid, wvalid, bready, wlast}, 0);
    chk(awaddr == 32'h0, "rst_awaddr", awaddr, 0);
    mon_en = 1'b1;
  endtask

  task automatic start_run(input logic [31:0] base);
    bursts_seen = 0;
    beats_total = 0;
    fill_acc = 0;
    for (int k = 0; k < NBURST; k++)
      exp_addr.push_back(base + 32'(k) * 32'd512);
    @(posedge clk);
    #1;
    awaddr_start = base;
    write_start = 1'b1;
    @(posedge clk);
    #1;
    write_start = 1'b0;
    awaddr_start = $urandom;
    @(negedge clk);
    #1;
    chk(write_err == 1'b0, "err_clear_on_start", write_err, 0);
  endtask

  task automatic run_test(input logic [31:0] base, input bit fill_pulse,
                          input bit end_err);
    int n;
    start_run(base);
    if (fill_pulse) begin
      n = 0;
      while (!(bursts_seen >= 2 && in_rdy) && n < 5000) begin
        @(negedge clk);
        n++;
      end
      chk(n < 5000, "fill_wait_timeout", n, 5000);
      @(posedge clk);
      #1;
      awaddr_start = 32'hDEAD_0000;
      write_start = 1'b1;
      @(posedge clk);
      #1;
      write_start = 1'b0;
    end
    n = 0;
    while (!write_done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk(write_done == 1'b1, "run_timeout", write_done, 1);
    repeat (3) @(negedge clk);
    chk(bursts_seen == NBURST, "burst_count", bursts_seen, NBURST);
    chk(beats_total == TOTAL, "beat_count", beats_total, TOTAL);
    chk(exp_data.size() == 0, "data_left", exp_data.size(), 0);
    chk(exp_addr.size() == 0, "addr_left", exp_addr.size(), 0);
    chk(write_err == end_err, "end_err", write_err, end_err);
  endtask

  initial begin
    int n;
    do_reset();

    // all readies held high
    aw_delay = 0;
    run_test(32'h1000_0000, 1'b0, 1'b0);

    // slow address acceptance
    aw_delay = 5;
    run_test(32'h2000_0400, 1'b0, 1'b0);

    // random gaps, stray start during FILL
    in_rand = 1; wr_rand = 1; b_rand = 1; aw_rand = 1;
    run_test({$urandom_range(0, 32'h7F_FFFF), 9'h0}, 1'b1, 1'b0);

    // error response on third burst, address wrap
    bad_burst = 2;
    run_test(32'hFFFF_F000, 1'b0, 1'b1);
    bad_burst = -1;

    // reset in the middle of a W burst
    start_run(32'h3000_0000);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(bursts_seen >= 1 && wvalid && beat_in_burst == 7)
               && n < 5000);
    chk(n < 5000, "beat7_timeout", n, 5000);
    #1;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk(wvalid == 1'b0, "rst_mid_wvalid", wvalid, 0);
    chk(write_done == 1'b1, "rst_mid_done", write_done, 1);
    chk({in_rdy, awvalid, bready} == 3'b0, "rst_mid_ctrl",
        {in_rdy, awvalid, bready}, 0);
    do_reset();
    run_test(32'h4000_0200, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
